// File: rtl/avalon_burst_reader_pkg.sv
// avalon_burst_reader_pkg: FSM states, burst sizing and FIFO counter width helpers
package avalon_burst_reader_pkg;
  typedef enum logic [1:0] {IDLE, REQ, DRAIN, DONE} state_t;
  localparam int DEF_FIFO_DEPTH = 64;
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
  function automatic logic [23:0] min_bc(input logic [23:0] burst_len, input logic [23:0] remaining);
    return remaining < burst_len ? remaining : burst_len;
  endfunction
endpackage

// File: rtl/avalon_burst_reader_if.sv
// avalon_if: Avalon-MM burst bus with host and agent views
interface avalon_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32, parameter int BURSTCOUNT_W = 6);
  logic [ADDR_W-1:0] address;
  logic read;
  logic write;
  logic [BURSTCOUNT_W-1:0] burstcount;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0] writedata;
  logic waitrequest;
  logic [DATA_W-1:0] readdata;
  logic readdatavalid;
  modport host (output address, read, write, burstcount, byteenable, writedata,
                input waitrequest, readdata, readdatavalid);
  modport agent (input address, read, write, burstcount, byteenable, writedata,
                 output waitrequest, readdata, readdatavalid);
endinterface

// File: rtl/avalon_burst_reader_fifo.sv
// burst_reader_fifo: synchronous show-ahead FIFO; a word pushed in one cycle is readable the next
module burst_reader_fifo
  import avalon_burst_reader_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = fifo_cnt_w(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wr_data;
endmodule

// File: rtl/avalon_burst_reader.sv
// avalon_burst_reader: credit-based Avalon-MM burst reader streaming a buffer out as valid/ready.
// Define AVALON_BURST_READER_LOOP_EN to re-read the buffer continuously until reset.
module avalon_burst_reader
  import avalon_burst_reader_pkg::*;
#(
  parameter int DATA_BYTES   = 4,
  parameter int BURSTCOUNT_W = 6,
  parameter int BURST_LEN    = 16,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  avalon_if.host                  avm,
  input  logic                    start,
  input  logic [31:0]             base_addr,
  input  logic [23:0]             nb_words,
  output logic                    busy,
  output logic                    done,
  output logic [8*DATA_BYTES-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready
);
  localparam int CW = fifo_cnt_w(FIFO_DEPTH);
  state_t state, next_state;
  logic [31:0] addr, step_addr, next_addr;
  logic [23:0] remaining, bc, next_rem;
  logic [CW-1:0] outstanding, fifo_count;
  logic fifo_full, fifo_empty, push, pop, credit_ok, accept, last_burst, leave_req, drain_done;
  assign bc = min_bc(24'(BURST_LEN), remaining);
  // Credits only grow while a request waits, so read/address/burstcount stay stable under waitrequest
  assign credit_ok = 32'(fifo_count) + 32'(outstanding) + 32'(bc) <= 32'(FIFO_DEPTH);
  assign avm.read = state == REQ && credit_ok;
  assign avm.address = avm.read ? addr : '0;
  assign avm.burstcount = avm.read ? BURSTCOUNT_W'(bc) : '0;
  assign avm.write = 1'b0;
  assign avm.byteenable = '1;
  assign avm.writedata = '0;
  assign accept = avm.read && !avm.waitrequest;
  assign last_burst = remaining == bc;
  assign step_addr = addr + 32'(bc) * 32'(DATA_BYTES);
  // Data arriving with nothing outstanding belongs to a transfer aborted by reset
  assign push = avm.readdatavalid && outstanding != '0 && !fifo_full;
  assign out_valid = !fifo_empty;
  assign pop = out_valid && out_ready;
  assign drain_done = outstanding == '0 && (fifo_empty || (fifo_count == CW'(1) && pop));
  assign busy = state != IDLE;
`ifdef AVALON_BURST_READER_LOOP_EN
  logic [31:0] base_q;
  logic [23:0] nb_q, pop_cnt;
  logic pass_done;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      base_q <= '0;
      nb_q <= '0;
      pop_cnt <= '0;
      pass_done <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        base_q <= base_addr;
        nb_q <= nb_words;
      end
      pass_done <= pop && pop_cnt == nb_q - 24'd1;
      pop_cnt <= state == IDLE ? '0 : !pop ? pop_cnt : pop_cnt == nb_q - 24'd1 ? '0 : pop_cnt + 24'd1;
    end
  assign next_addr = last_burst ? base_q : step_addr;
  assign next_rem = last_burst ? nb_q : remaining - bc;
  assign leave_req = 1'b0;
  assign done = state == DONE || pass_done;
`else
  assign next_addr = step_addr;
  assign next_rem = remaining - bc;
  assign leave_req = last_burst;
  assign done = state == DONE;
`endif
  always_comb begin
    next_state = state;
    next_state = state == IDLE  ? (start ? (nb_words == '0 ? DONE : REQ) : IDLE)
               : state == REQ   ? (accept && leave_req ? DRAIN : REQ)
               : state == DRAIN ? (drain_done ? DONE : DRAIN)
               : IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      addr <= '0;
      remaining <= '0;
      outstanding <= '0;
    end else begin
      state <= next_state;
      outstanding <= outstanding + (accept ? CW'(bc) : '0) - CW'(push);
      if (state == IDLE && start) begin
        addr <= base_addr;
        remaining <= nb_words;
      end else if (accept) begin
        addr <= next_addr;
        remaining <= next_rem;
      end
    end
  burst_reader_fifo #(.WIDTH(8*DATA_BYTES), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(reset),
    .push(push),
    .pop(pop),
    .wr_data(avm.readdata),
    .rd_data(out_data),
    .count(fifo_count),
    .full(fifo_full),
    .empty(fifo_empty)
  );
endmodule

// File: tb/tb_avalon_burst_reader.sv
// tb_avalon_burst_reader: directed bench with an Avalon agent model (2-cycle latency, optional stalls)
module tb_avalon_burst_reader;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, out_ready = 1'b0;
  logic [31:0] base_addr = '0;
  logic [23:0] nb_words = '0;
  logic busy, done, out_valid;
  logic [31:0] out_data;
  int tests = 0, failed = 0, cyc = 0, wait_n = 0, wcnt = 0;
  typedef struct { logic [31:0] a; int t; } pend_t;
  pend_t pend[$];
  logic [31:0] burst_addr[$];
  int burst_bc[$];
  int req_words = 0, read_cycles = 0, stall_cycles = 0, stall_err = 0;
  logic [31:0] st_addr;
  logic [5:0] st_bc;
  int rx_idx = 0, data_err = 0, done_cnt = 0, hold_err = 0, done_cyc = 0, done_gap = 0, done_rx = 0, last_pop_cyc = 0;
  logic prev_hold = 1'b0;
  logic [31:0] prev_data;
  logic [31:0] exp_base = '0;
  int exp_nb = 1, rx_base = 0, b0 = 0, rq0 = 0, de0 = 0, dc0 = 0, he0 = 0, sc0 = 0, se0 = 0, rc0 = 0, t0 = 0;

  avalon_if #(.ADDR_W(32), .DATA_W(32), .BURSTCOUNT_W(6)) avm ();

  avalon_burst_reader #(.DATA_BYTES(4), .BURSTCOUNT_W(6), .BURST_LEN(16), .FIFO_DEPTH(64)) dut (
    .clk(clk), .reset(reset), .avm(avm), .start(start), .base_addr(base_addr), .nb_words(nb_words),
    .busy(busy), .done(done), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  // Agent and stream monitor run mid-cycle, away from the sampling edge
  always @(negedge clk) begin
    if (avm.read) begin
      read_cycles++;
      if (wcnt == 0) begin
        st_addr = avm.address;
        st_bc = avm.burstcount;
      end else if (avm.address !== st_addr || avm.burstcount !== st_bc) stall_err++;
      if (wcnt < wait_n) begin
        avm.waitrequest = 1'b1;
        wcnt++;
        stall_cycles++;
      end else begin
        avm.waitrequest = 1'b0;
        wcnt = 0;
        burst_addr.push_back(avm.address);
        burst_bc.push_back(int'(avm.burstcount));
        req_words += int'(avm.burstcount);
        for (int i = 0; i < int'(avm.burstcount); i++) pend.push_back('{avm.address + 32'(4 * i), cyc + 2 + i});
      end
    end else begin
      if (wcnt != 0 && reset) stall_err++;
      wcnt = 0;
      avm.waitrequest = 1'b0;
    end
    if (pend.size() > 0 && pend[0].t <= cyc) begin
      avm.readdatavalid = 1'b1;
      avm.readdata = mem_word(pend[0].a);
      void'(pend.pop_front());
    end else begin
      avm.readdatavalid = 1'b0;
      avm.readdata = '0;
    end
    if (reset) begin
      if (prev_hold && (!out_valid || out_data !== prev_data)) hold_err++;
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        done_gap = cyc - last_pop_cyc;
        done_rx = rx_idx - rx_base;
      end
      if (out_valid && out_ready) begin
        if (out_data !== mem_word(exp_base + 32'(4 * ((rx_idx - rx_base) % exp_nb)))) data_err++;
        rx_idx++;
        last_pop_cyc = cyc;
      end
    end else prev_hold = 1'b0;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [31:0] b, input logic [23:0] n);
    b0 = burst_addr.size(); rq0 = req_words; rx_base = rx_idx; de0 = data_err; dc0 = done_cnt;
    he0 = hold_err; sc0 = stall_cycles; se0 = stall_err; rc0 = read_cycles;
    exp_base = b; exp_nb = n == 0 ? 1 : int'(n);
    base_addr = b; nb_words = n; start = 1'b1; t0 = cyc;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget);
    for (int i = 0; i < budget && done_cnt - dc0 < n; i++) tick(1);
  endtask

  initial begin
    tick(2);
    check("rst_read", avm.read, 0);
    check("rst_address", avm.address, 0);
    check("rst_burstcount", avm.burstcount, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_write", avm.write, 0);
    check("rst_byteenable", avm.byteenable, 4'hF);
    reset = 1'b1;
    tick(2);
`ifdef AVALON_BURST_READER_LOOP_EN
    out_ready = 1'b1;
    go(32'h6000, 24'd20);
    check("loop_first_read", avm.read, 1);
    wait_done(3, 600);
    check("loop_done_cnt", done_cnt - dc0, 3);
    check("loop_done_rx", done_rx, 60);
    check("loop_done_gap", done_gap, 1);
    check("loop_busy", busy, 1);
    check("loop_b1_addr", burst_addr[b0+1], 32'h6040);
    check("loop_b1_bc", burst_bc[b0+1], 4);
    check("loop_b2_addr", burst_addr[b0+2], 32'h6000);
    check("loop_data_err", data_err - de0, 0);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    check("loop_rst_busy", busy, 0);
`else
    // Straight transfer, zero wait, always ready
    out_ready = 1'b1;
    go(32'h1000, 24'd40);
    check("a_read_t1", avm.read, 1);
    check("a_addr_t1", avm.address, 32'h1000);
    check("a_bc_t1", avm.burstcount, 16);
    wait_done(1, 300);
    tick(3);
    check("a_bursts", burst_addr.size() - b0, 3);
    check("a_b1_addr", burst_addr[b0+1], 32'h1040);
    check("a_b2_addr", burst_addr[b0+2], 32'h1080);
    check("a_b1_bc", burst_bc[b0+1], 16);
    check("a_b2_bc", burst_bc[b0+2], 8);
    check("a_words", rx_idx - rx_base, 40);
    check("a_data_err", data_err - de0, 0);
    check("a_done_cnt", done_cnt - dc0, 1);
    check("a_done_gap", done_gap, 1);
    check("a_busy_end", busy, 0);
    // Back-pressure: credits stop requests at the FIFO depth
    out_ready = 1'b0;
    go(32'h2000, 24'd100);
    tick(100);
    check("b_req_stalled", req_words - rq0, 64);
    check("b_read_low", avm.read, 0);
    check("b_no_pop", rx_idx - rx_base, 0);
    out_ready = 1'b1;
    wait_done(1, 600);
    tick(3);
    check("b_req_total", req_words - rq0, 100);
    check("b_bursts", burst_addr.size() - b0, 7);
    check("b_words", rx_idx - rx_base, 100);
    check("b_data_err", data_err - de0, 0);
    check("b_hold_err", hold_err - he0, 0);
    check("b_done_cnt", done_cnt - dc0, 1);
    // Five wait states per burst
    wait_n = 5;
    go(32'h3000, 24'd40);
    wait_done(1, 600);
    tick(3);
    wait_n = 0;
    check("c_stall_cycles", stall_cycles - sc0, 15);
    check("c_stall_err", stall_err - se0, 0);
    check("c_b2_addr", burst_addr[b0+2], 32'h3080);
    check("c_words", rx_idx - rx_base, 40);
    check("c_data_err", data_err - de0, 0);
    // Zero-length transfer and ignored second start
    go(32'h0, 24'd0);
    check("d_busy_t1", busy, 1);
    check("d_done_t1", done, 1);
    start = 1'b1;
    nb_words = 24'd5;
    tick(1);
    start = 1'b0;
    tick(20);
    check("d_done_cyc", done_cyc - t0, 1);
    check("d_no_read", read_cycles - rc0, 0);
    check("d_done_cnt", done_cnt - dc0, 1);
    check("d_busy_end", busy, 0);
    // Reset during the second burst, then a short clean transfer
    go(32'h4000, 24'd40);
    for (int i = 0; i < 50 && burst_addr.size() - b0 < 2; i++) tick(1);
    tick(2);
    reset = 1'b0;
    #1;
    check("e_rst_read", avm.read, 0);
    check("e_rst_address", avm.address, 0);
    check("e_rst_burstcount", avm.burstcount, 0);
    check("e_rst_busy", busy, 0);
    check("e_rst_out_valid", out_valid, 0);
    check("e_rst_done", done, 0);
    tick(1);
    reset = 1'b1;
    tick(40);
    check("e_stale_dropped", out_valid, 0);
    go(32'h5000, 24'd5);
    wait_done(1, 100);
    tick(3);
    check("e_bc", burst_bc[b0], 5);
    check("e_words", rx_idx - rx_base, 5);
    check("e_data_err", data_err - de0, 0);
    check("e_done_cnt", done_cnt - dc0, 1);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", tests);
    $fatal(1, "watchdog");
  end
endmodule
